// File: rtl/spi_ram_pkg.sv
// Shared command encodings, arbiter state type and small decode helpers
// for the SPI/host RAM arbiter.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    H_ADDR  = 3'd1,
    H_DATA  = 3'd2,
    H_RWAIT = 3'd3,
    S_RWAIT = 3'd4
  } arb_state_t;

  // An address command opens a two-command RAM transaction.
  function automatic logic cmd_is_addr(input logic [1:0] cmd);
    return (cmd == CMD_WR_ADDR) || (cmd == CMD_RD_ADDR);
  endfunction

endpackage

// File: rtl/spi_cmd_skid.sv
// One-entry holding buffer for SPI commands that arrive while the RAM is
// busy. A push into a full buffer that is not being drained in the same
// cycle is dropped and raises a sticky overflow flag.
module spi_cmd_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         ovf
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;
  logic         ovf_q,   ovf_d;

  // Next-state for the single entry and the sticky overflow flag.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (push && (pop || !valid_q)) begin
      // Free slot, or the current entry leaves this cycle: take the new one.
      valid_d = 1'b1;
      data_d  = push_data;
    end else if (push) begin
      // Full and not draining: the new command is lost.
      ovf_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port, two-command RAM between the SPI slave and a local
// host port. SPI commands always win; between an SPI address command and
// its data command the RAM is locked to SPI so its address latch is never
// overwritten by a host access. A timer force-releases a stale lock.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE    = 8,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] spi_rx_data,
  input  logic                 spi_rx_valid,
  output logic [ADDR_SIZE-1:0] spi_tx_data,
  output logic                 spi_tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [ADDR_SIZE-1:0] host_wdata,
  output logic                 host_ack,
  output logic [ADDR_SIZE-1:0] host_rdata,
  output logic [ADDR_SIZE+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [ADDR_SIZE-1:0] ram_dout,
  input  logic                 ram_tx_valid,
  output logic                 spi_lock,
  output logic                 ovf_err
);

  localparam int CW = ADDR_SIZE + 2;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOCK_TIMEOUT - 1);

  arb_state_t          state_q,        state_d;
  logic [CW-1:0]       ram_din_q,      ram_din_d;
  logic                ram_rx_valid_q, ram_rx_valid_d;
  logic [ADDR_SIZE-1:0] spi_tx_data_q, spi_tx_data_d;
  logic                spi_tx_valid_q, spi_tx_valid_d;
  logic                host_ack_q,     host_ack_d;
  logic [ADDR_SIZE-1:0] host_rdata_q,  host_rdata_d;
  logic                lock_q,         lock_d;
  logic [TW-1:0]       timer_q,        timer_d;

  logic                pend_valid;
  logic [CW-1:0]       pend_data;
  logic                pend_ovf;
  logic                skid_push;
  logic                skid_pop;
  logic [CW-1:0]       fwd_cmd;
  logic                timeout;

  // Anything arriving while the RAM is busy, or while an older command is
  // still queued, goes through the buffer so ordering is preserved.
  assign skid_push = spi_rx_valid && ((state_q != IDLE) || pend_valid);
  assign skid_pop  = (state_q == IDLE) && pend_valid;

  spi_cmd_skid #(
    .W (CW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data (spi_rx_data),
    .valid     (pend_valid),
    .data      (pend_data),
    .ovf       (pend_ovf)
  );

  // Arbitration FSM, lock/timeout bookkeeping and registered outputs.
  always_comb begin
    state_d        = state_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    spi_tx_data_d  = spi_tx_data_q;
    spi_tx_valid_d = 1'b0;
    host_ack_d     = 1'b0;
    host_rdata_d   = host_rdata_q;
    lock_d         = lock_q;
    timer_d        = timer_q;
    fwd_cmd        = pend_valid ? pend_data : spi_rx_data;
    timeout        = lock_q && (timer_q == TIMER_LAST);

    // Idle-lock timer; a forwarded SPI command below restarts it.
    if (timeout) begin
      lock_d  = 1'b0;
      timer_d = '0;
    end else if (lock_q) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (pend_valid || spi_rx_valid) begin
          // Older queued command goes first; a fresh one is buffered.
          ram_din_d      = fwd_cmd;
          ram_rx_valid_d = 1'b1;
          timer_d        = '0;
          if (cmd_is_addr(fwd_cmd[CW-1:CW-2])) begin
            lock_d = 1'b1;
          end else if (fwd_cmd[CW-1:CW-2] == CMD_WR_DATA) begin
            lock_d = 1'b0;
          end else begin
            lock_d = lock_q;
          end
          if (fwd_cmd[CW-1:CW-2] == CMD_RD_DATA) begin
            state_d = S_RWAIT;
          end else begin
            state_d = IDLE;
          end
        end else if (host_req && !lock_q && !host_ack_q) begin
          // host_ack_q blocks a re-grant while the host still holds req
          // in the cycle it sees its completion.
          state_d = H_ADDR;
        end else begin
          state_d = IDLE;
        end
      end

      H_ADDR: begin
        ram_din_d      = {(host_we ? CMD_WR_ADDR : CMD_RD_ADDR), host_addr};
        ram_rx_valid_d = 1'b1;
        state_d        = H_DATA;
      end

      H_DATA: begin
        ram_rx_valid_d = 1'b1;
        if (host_we) begin
          ram_din_d  = {CMD_WR_DATA, host_wdata};
          host_ack_d = 1'b1;
          state_d    = IDLE;
        end else begin
          ram_din_d = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
          state_d   = H_RWAIT;
        end
      end

      H_RWAIT: begin
        if (ram_tx_valid) begin
          host_rdata_d = ram_dout;
          host_ack_d   = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = H_RWAIT;
        end
      end

      S_RWAIT: begin
        // Data that arrives in the timeout cycle is still delivered.
        if (ram_tx_valid) begin
          spi_tx_data_d  = ram_dout;
          spi_tx_valid_d = 1'b1;
          lock_d         = 1'b0;
          timer_d        = '0;
          state_d        = IDLE;
        end else if (timeout) begin
          state_d = IDLE;
        end else begin
          state_d = S_RWAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, lock, timer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      spi_tx_data_q  <= '0;
      spi_tx_valid_q <= 1'b0;
      host_ack_q     <= 1'b0;
      host_rdata_q   <= '0;
      lock_q         <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
      spi_tx_data_q  <= spi_tx_data_d;
      spi_tx_valid_q <= spi_tx_valid_d;
      host_ack_q     <= host_ack_d;
      host_rdata_q   <= host_rdata_d;
      lock_q         <= lock_d;
      timer_q        <= timer_d;
    end
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign spi_tx_data  = spi_tx_data_q;
  assign spi_tx_valid = spi_tx_valid_q;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;
  assign spi_lock     = lock_q;
  assign ovf_err      = pend_ovf;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: a cycle table for the basic SPI/host
// traffic and the lock, then hand-written sequences for collision,
// overflow, lock timeout and reset during a host read.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout;
  logic       ram_tx_valid;
  logic       spi_lock;
  logic       ovf_err;

  int n_vec = 0;
  int n_err = 0;

  spi_ram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid),
    .spi_lock     (spi_lock),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  // Behavioural two-command RAM: one-cycle read latency.
  logic [7:0] mem [256];
  logic [7:0] m_addr;
  logic       model_tx_q;
  logic [7:0] model_dout_q;
  logic       model_en;
  logic       man_tx;

  assign ram_tx_valid = model_tx_q | man_tx;
  assign ram_dout     = model_dout_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_tx_q   <= 1'b0;
      model_dout_q <= 8'h00;
    end else begin
      model_tx_q <= 1'b0;
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00:   m_addr <= ram_din[7:0];
          2'b01:   mem[m_addr] <= ram_din[7:0];
          2'b10:   m_addr <= ram_din[7:0];
          default: begin
            if (model_en) begin
              model_tx_q   <= 1'b1;
              model_dout_q <= mem[m_addr];
            end
          end
        endcase
      end
    end
  end

  typedef struct {
    logic       srv;
    logic [9:0] sdat;
    logic       hreq;
    logic       hwe;
    logic [7:0] haddr;
    logic [7:0] hwd;
    logic       rv;
    logic [9:0] din;
    logic       lock;
    logic       ack;
    logic [7:0] rdata;
    logic       stv;
    logic [7:0] stdat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic srv, input logic [9:0] sdat,
                              input logic hreq, input logic hwe,
                              input logic [7:0] haddr, input logic [7:0] hwd,
                              input logic rv, input logic [9:0] din,
                              input logic lock, input logic ack,
                              input logic [7:0] rdata, input logic stv,
                              input logic [7:0] stdat);
    vec_t v;
    v.srv = srv; v.sdat = sdat; v.hreq = hreq; v.hwe = hwe;
    v.haddr = haddr; v.hwd = hwd; v.rv = rv; v.din = din; v.lock = lock;
    v.ack = ack; v.rdata = rdata; v.stv = stv; v.stdat = stdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi(input logic v, input logic [9:0] d);
    spi_rx_valid = v;
    spi_rx_data  = d;
  endtask

  task automatic host(input logic req, input logic we, input logic [7:0] a, input logic [7:0] wd);
    host_req   = req;
    host_we    = we;
    host_addr  = a;
    host_wdata = wd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ram_rx_valid"}, ram_rx_valid, 16'h0);
    chk({tag, ".ram_din"},      ram_din,      16'h0);
    chk({tag, ".host_ack"},     host_ack,     16'h0);
    chk({tag, ".host_rdata"},   host_rdata,   16'h0);
    chk({tag, ".spi_tx_valid"}, spi_tx_valid, 16'h0);
    chk({tag, ".spi_tx_data"},  spi_tx_data,  16'h0);
    chk({tag, ".spi_lock"},     spi_lock,     16'h0);
    chk({tag, ".ovf_err"},      ovf_err,      16'h0);
  endtask

  initial begin
    logic bad;

    // Basic SPI write then host read of the written location.
    vecs.push_back(mk(1'b1,10'h0FF,1'b0,1'b0,8'h00,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b1,10'h1FC,1'b0,1'b0,8'h00,8'h00, 1'b1,10'h0FF,1'b1,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b0,1'b0,8'h00,8'h00, 1'b1,10'h1FC,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b0,8'hFF,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b0,8'hFF,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b0,8'hFF,8'h00, 1'b1,10'h2FF,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b0,8'hFF,8'h00, 1'b1,10'h300,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b0,8'hFF,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b0,8'hFF,8'h00, 1'b0,10'h000,1'b0,1'b1,8'hFC,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b0,1'b0,8'h00,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b0,1'b0,8'h00,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    // SPI lock holds off a host write until the SPI read completes.
    vecs.push_back(mk(1'b1,10'h2FF,1'b0,1'b0,8'h00,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b1,10'h2FF,1'b1,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b0,10'h000,1'b1,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b0,10'h000,1'b1,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b1,10'h300,1'b1,1'b1,8'h10,8'h55, 1'b0,10'h000,1'b1,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b1,10'h300,1'b1,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b0,10'h000,1'b1,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b1,8'hFC));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b1,10'h010,1'b0,1'b0,8'h00,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b1,1'b1,8'h10,8'h55, 1'b1,10'h155,1'b0,1'b1,8'hFC,1'b0,8'h00));
    vecs.push_back(mk(1'b0,10'h000,1'b0,1'b0,8'h00,8'h00, 1'b0,10'h000,1'b0,1'b0,8'h00,1'b0,8'h00));

    // Reset for two cycles: every output low.
    rst_n    = 1'b0;
    model_en = 1'b1;
    man_tx   = 1'b0;
    spi(1'b0, 10'h000);
    host(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Cycle table: outputs checked at each falling edge, then inputs applied.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d.rv", i), ram_rx_valid, vecs[i].rv);
      if (vecs[i].rv) chk($sformatf("tbl%0d.din", i), ram_din, vecs[i].din);
      chk($sformatf("tbl%0d.lock", i), spi_lock, vecs[i].lock);
      chk($sformatf("tbl%0d.ack", i), host_ack, vecs[i].ack);
      if (vecs[i].ack) chk($sformatf("tbl%0d.rdata", i), host_rdata, vecs[i].rdata);
      chk($sformatf("tbl%0d.stv", i), spi_tx_valid, vecs[i].stv);
      if (vecs[i].stv) chk($sformatf("tbl%0d.stdat", i), spi_tx_data, vecs[i].stdat);
      spi(vecs[i].srv, vecs[i].sdat);
      host(vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd);
    end

    // Collision: SPI command during H_ADDR waits for the host write.
    @(negedge clk); host(1'b1, 1'b1, 8'h20, 8'h66);
    @(negedge clk); chk("col.haddr_rv", ram_rx_valid, 16'h0); spi(1'b1, 10'h0AA);
    @(negedge clk); spi(1'b0, 10'h000);
    chk("col.addr_rv", ram_rx_valid, 16'h1); chk("col.addr_din", ram_din, 16'h020);
    @(negedge clk);
    chk("col.data_din", ram_din, 16'h166); chk("col.ack", host_ack, 16'h1);
    @(negedge clk); host(1'b0, 1'b0, 8'h00, 8'h00);
    chk("col.pend_rv", ram_rx_valid, 16'h1); chk("col.pend_din", ram_din, 16'h0AA);
    chk("col.lock", spi_lock, 16'h1);
    spi(1'b1, 10'h1BB);
    @(negedge clk); spi(1'b0, 10'h000);
    chk("col.unlock_din", ram_din, 16'h1BB); chk("col.unlock", spi_lock, 16'h0);

    // Overflow: second SPI command while the buffer is full is dropped.
    chk("ovf.before", ovf_err, 16'h0);
    host(1'b1, 1'b1, 8'h21, 8'h67);
    @(negedge clk); spi(1'b1, 10'h0CC);
    @(negedge clk); spi(1'b1, 10'h1DD);
    chk("ovf.addr_din", ram_din, 16'h021);
    @(negedge clk); spi(1'b0, 10'h000);
    chk("ovf.data_din", ram_din, 16'h167); chk("ovf.ack", host_ack, 16'h1);
    chk("ovf.flag", ovf_err, 16'h1);
    @(negedge clk); host(1'b0, 1'b0, 8'h00, 8'h00);
    chk("ovf.pend_din", ram_din, 16'h0CC); chk("ovf.pend_rv", ram_rx_valid, 16'h1);
    @(negedge clk);
    chk("ovf.dropped_rv", ram_rx_valid, 16'h0);
    spi(1'b1, 10'h1EE);
    @(negedge clk); spi(1'b0, 10'h000);
    chk("ovf.unlock_din", ram_din, 16'h1EE); chk("ovf.unlock", spi_lock, 16'h0);

    // Timeout: lock held for exactly 255 idle cycles, then the host proceeds.
    spi(1'b1, 10'h012);
    @(negedge clk); spi(1'b0, 10'h000); host(1'b1, 1'b1, 8'h30, 8'h77);
    chk("to.fwd_din", ram_din, 16'h012); chk("to.lock_set", spi_lock, 16'h1);
    bad = 1'b0;
    for (int k = 2; k <= 255; k++) begin
      @(negedge clk);
      if (ram_rx_valid || !spi_lock) bad = 1'b1;
    end
    chk("to.held", bad, 16'h0);
    @(negedge clk); chk("to.released", spi_lock, 16'h0);
    @(negedge clk); chk("to.grant_rv", ram_rx_valid, 16'h0);
    @(negedge clk); chk("to.addr_din", ram_din, 16'h030);
    @(negedge clk); chk("to.data_din", ram_din, 16'h177); chk("to.ack", host_ack, 16'h1);
    @(negedge clk); host(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset while waiting for host read data; a late RAM strobe is ignored.
    model_en = 1'b0;
    @(negedge clk); host(1'b1, 1'b0, 8'h30, 8'h00);
    @(negedge clk);
    @(negedge clk); chk("rst.raddr_din", ram_din, 16'h230);
    @(negedge clk); chk("rst.rdata_din", ram_din, 16'h300);
    @(negedge clk); chk("rst.wait_ack", host_ack, 16'h0);
    rst_n = 1'b0; host(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); chk_all_zero("rst.in");
    @(negedge clk); rst_n = 1'b1; man_tx = 1'b1;
    @(negedge clk); man_tx = 1'b0;
    chk_all_zero("rst.after");
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (host_ack || spi_tx_valid || ram_rx_valid) bad = 1'b1;
    end
    chk("rst.no_late", bad, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
